// File: rtl/lsu_byte_seq_if.sv
// lsu_byte_seq_if: request/response and dual byte-port RAM bundle.
// slave = sequencer side, master = execute stage plus RAM side.
interface lsu_byte_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we1;
    logic        mem_we2;
    logic [31:0] mem_addr1;
    logic [31:0] mem_addr2;
    logic [7:0]  mem_wdata1;
    logic [7:0]  mem_wdata2;
    logic [7:0]  mem_rdata1;
    logic [7:0]  mem_rdata2;

    modport slave (
        input  req_valid, req_we, req_funct3,
        input  req_addr, req_wdata,
        input  mem_rdata1, mem_rdata2,
        output req_ready, resp_valid,
        output resp_rdata, resp_err,
        output mem_we1, mem_we2,
        output mem_addr1, mem_addr2,
        output mem_wdata1, mem_wdata2
    );

    modport master (
        output req_valid, req_we, req_funct3,
        output req_addr, req_wdata,
        output mem_rdata1, mem_rdata2,
        input  req_ready, resp_valid,
        input  resp_rdata, resp_err,
        input  mem_we1, mem_we2,
        input  mem_addr1, mem_addr2,
        input  mem_wdata1, mem_wdata2
    );
endinterface

// File: rtl/lsu_byte_seq.sv
// lsu_byte_seq: RV32I load/store sequencer over two 8-bit RAM ports.
// Ports: clk, rst (sync, active-high), bus (lsu_byte_seq_if.slave).
// Optional MISALIGN_CHECK_EN rejects misaligned H/HU/W requests.
module lsu_byte_seq (
    input  logic          clk,
    input  logic          rst,
    lsu_byte_seq_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC0,
        S_ACC1,
        S_WAIT,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  f3_q, f3_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] lo_q, lo_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] a1_q, a1_d;
    logic [31:0] a2_q, a2_d;
    logic [7:0]  wd1_q, wd1_d;
    logic [7:0]  wd2_q, wd2_d;

    logic        bad;
    logic        wide;
    logic        we1_c;
    logic        we2_c;
    logic [31:0] word;
    logic [31:0] ext;

    always_comb begin
        bad = (bus.req_funct3 == 3'b011) ||
              (bus.req_funct3 == 3'b110) ||
              (bus.req_funct3 == 3'b111) ||
              (bus.req_we && bus.req_funct3[2]);
`ifdef MISALIGN_CHECK_EN
        if (bus.req_funct3[1:0] == 2'b01 &&
            bus.req_addr[0])
            bad = 1'b1;
        if (bus.req_funct3[1:0] == 2'b10 &&
            bus.req_addr[1:0] != 2'b00)
            bad = 1'b1;
`endif
    end

    assign wide = (f3_q[1:0] == 2'b10);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        lo_d    = lo_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        a1_d    = a1_q;
        a2_d    = a2_q;
        wd1_d   = wd1_q;
        wd2_d   = wd2_q;
        we1_c   = 1'b0;
        we2_c   = 1'b0;
        word    = '0;
        ext     = '0;

        unique case (1'b1)
            (state_q == S_IDLE): begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    f3_d    = bus.req_funct3;
                    we_d    = bus.req_we;
                    wdata_d = bus.req_wdata;
                    rdata_d = '0;
                    err_d   = bad;
                    state_d = bad ? S_DONE : S_ACC0;
                end
            end
            (state_q == S_ACC0): begin
                a1_d    = addr_q;
                a2_d    = addr_q + 32'd1;
                wd1_d   = wdata_q[7:0];
                wd2_d   = wdata_q[15:8];
                we1_c   = we_q;
                we2_c   = we_q && (f3_q[1:0] != 2'b00);
                state_d = wide ? S_ACC1 : S_WAIT;
            end
            (state_q == S_ACC1): begin
                a1_d    = addr_q + 32'd2;
                a2_d    = addr_q + 32'd3;
                wd1_d   = wdata_q[23:16];
                wd2_d   = wdata_q[31:24];
                we1_c   = we_q;
                we2_c   = we_q;
                lo_d    = {bus.mem_rdata2, bus.mem_rdata1};
                state_d = S_WAIT;
            end
            (state_q == S_WAIT): begin
                // Last read phase lands now; fold it in
                // with bytes 0,1 held from ACC1 if wide.
                if (wide)
                    word = {bus.mem_rdata2,
                            bus.mem_rdata1, lo_q};
                else
                    word = {16'h0, bus.mem_rdata2,
                            bus.mem_rdata1};
                case (f3_q)
                    3'b000:  ext = {{24{word[7]}},
                                    word[7:0]};
                    3'b001:  ext = {{16{word[15]}},
                                    word[15:0]};
                    3'b100:  ext = {24'h0, word[7:0]};
                    3'b101:  ext = {16'h0, word[15:0]};
                    default: ext = word;
                endcase
                rdata_d = we_q ? 32'h0 : ext;
                state_d = S_DONE;
            end
            (state_q == S_DONE): begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            a1_q    <= '0;
            a2_q    <= '0;
            wd1_q   <= '0;
            wd2_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            wd1_q   <= wd1_d;
            wd2_q   <= wd2_d;
        end
    end

    // Ports show the live phase address/data and keep
    // it afterwards, so the hold regs track the _d value.
    assign bus.mem_addr1  = a1_d;
    assign bus.mem_addr2  = a2_d;
    assign bus.mem_wdata1 = wd1_d;
    assign bus.mem_wdata2 = wd2_d;
    assign bus.mem_we1    = we1_c && !rst;
    assign bus.mem_we2    = we2_c && !rst;

    assign bus.req_ready  = (state_q == S_IDLE) && !rst;
    assign bus.resp_valid = (state_q == S_DONE) && !rst;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_lsu_byte_seq.sv
// tb_lsu_byte_seq: directed bench with byte-RAM and
// transaction-level model for lsu_byte_seq.
module tb_lsu_byte_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_byte_seq_if bus ();
    lsu_byte_seq dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h",
                     nm, act, exp);
        end
    endtask

    localparam int NP = 19;
    localparam logic [31:0] PA [NP] = '{
        32'h100, 32'h101, 32'h102, 32'h103, 32'h7,
        32'hFFFF_FFFF, 32'h0, 32'h1, 32'h2,
        32'h3, 32'h4, 32'h5, 32'h6,
        32'h40, 32'h41, 32'h42, 32'h43,
        32'h22, 32'h23};
    localparam logic [7:0] PD [NP] = '{
        8'h78, 8'h56, 8'h34, 8'h12, 8'h80,
        8'h11, 8'h22, 8'h33, 8'h44,
        8'hA1, 8'hB2, 8'hC3, 8'hD4,
        8'h01, 8'h02, 8'h03, 8'h04,
        8'h5A, 8'h6B};

    logic [7:0] ram     [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];
    bit loaded = 1'b0;

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return 8'h00;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < NP; i++) ram[PA[i]] = PD[i];
            loaded = 1'b1;
        end
        bus.mem_rdata1 <= ram_rd(bus.mem_addr1);
        bus.mem_rdata2 <= ram_rd(bus.mem_addr2);
        if (bus.mem_we1) ram[bus.mem_addr1] = bus.mem_wdata1;
        if (bus.mem_we2) ram[bus.mem_addr2] = bus.mem_wdata2;
    end

    typedef struct {
        bit          legal;
        bit          we;
        int          n;
        int          lat;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        bit          err;
    } exp_t;

    exp_t pend;
    exp_t cur;

    function automatic exp_t model(input bit we,
                                   input logic [2:0] f3,
                                   input logic [31:0] a,
                                   input logic [31:0] wd);
        exp_t e;
        logic [31:0] w;
        e.we = we;
        e.a  = a;
        e.wd = wd;
        e.n  = (f3[1:0] == 2'd0) ? 1 :
               (f3[1:0] == 2'd1) ? 2 : 4;
        e.legal = !(f3 == 3'd3 || f3 == 3'd6 ||
                    f3 == 3'd7 || (we && f3[2]));
`ifdef MISALIGN_CHECK_EN
        if (e.n == 2 && a[0]) e.legal = 1'b0;
        if (e.n == 4 && a[1:0] != 2'b00) e.legal = 1'b0;
`endif
        e.err = !e.legal;
        e.lat = !e.legal ? 1 : (e.n == 4 ? 4 : 3);
        w = 32'h0;
        for (int k = 0; k < e.n; k++)
            w = w | (32'(ref_rd(a + 32'(k))) << (8 * k));
        e.rd = w;
        if (!f3[2] && e.n < 4 && w[8 * e.n - 1])
            e.rd = w - (32'd1 << (8 * e.n));
        if (we || !e.legal) e.rd = 32'h0;
        if (we && e.legal)
            for (int k = 0; k < e.n; k++)
                ref_mem[a + 32'(k)] = wd[8 * k +: 8];
        return e;
    endfunction

    int cyc = -1;

    always @(posedge clk) begin
        if (rst) cyc <= -1;
        else if (bus.req_valid && bus.req_ready) begin
            cyc <= 1;
            cur <= pend;
        end else if (cyc > 0 && cyc < cur.lat) cyc <= cyc + 1;
        else cyc <= -1;
    end

    int          resp_cnt = 0;
    int          last_lat = 0;
    logic [31:0] last_rd  = 32'h0;
    logic        last_err = 1'b0;

    always @(negedge clk) begin
        bit act;
        bit ewe;
        int k;
        if (rst) begin
            chk("rst_resp_valid", bus.resp_valid, 0);
            chk("rst_we1", bus.mem_we1, 0);
            chk("rst_we2", bus.mem_we2, 0);
            chk("rst_ready", bus.req_ready, 0);
        end else begin
            act = cyc > 0;
            chk("req_ready", bus.req_ready, !act);
            chk("resp_valid", bus.resp_valid,
                act && cyc == cur.lat);
            if (bus.resp_valid) begin
                resp_cnt++;
                last_lat = cyc;
                last_rd  = bus.resp_rdata;
                last_err = bus.resp_err;
            end
            if (act && cyc == cur.lat) begin
                chk("resp_rdata", bus.resp_rdata, cur.rd);
                chk("resp_err", bus.resp_err, cur.err);
            end
            for (int p = 0; p < 2; p++) begin
                k = 2 * (cyc - 1) + p;
                ewe = act && cur.legal && cur.we &&
                      cyc <= 2 && k < cur.n;
                chk(p ? "mem_we2" : "mem_we1",
                    p ? bus.mem_we2 : bus.mem_we1, ewe);
                if (act && cur.legal && cyc <= 2 &&
                    2 * (cyc - 1) < cur.n)
                    chk(p ? "mem_addr2" : "mem_addr1",
                        p ? bus.mem_addr2 : bus.mem_addr1,
                        cur.a + 32'(k));
                if (ewe)
                    chk(p ? "mem_wdata2" : "mem_wdata1",
                        p ? bus.mem_wdata2 : bus.mem_wdata1,
                        cur.wd[8 * k +: 8]);
            end
        end
    end

    int cnt0;

    task automatic send(input logic we, input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] wd);
        int t;
        pend = model(we, f3, a, wd);
        cnt0 = resp_cnt;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        t = 0;
        while (!bus.req_ready && t < 10) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("ready_wait", t, 0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] a,
                         input logic [31:0] wd);
        send(we, f3, a, wd);
        repeat (pend.lat) @(posedge clk);
        #1;
    endtask

    task automatic res(input string nm, input logic [31:0] rd,
                       input logic err, input int lat);
        chk({nm, "_count"}, resp_cnt, cnt0 + 1);
        chk({nm, "_rdata"}, last_rd, rd);
        chk({nm, "_err"}, last_err, err);
        chk({nm, "_lat"}, last_lat, lat);
    endtask

    initial begin
        for (int i = 0; i < NP; i++) ref_mem[PA[i]] = PD[i];
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_addr1", bus.mem_addr1, 0);
        chk("reset_addr2", bus.mem_addr2, 0);
        chk("reset_wdata1", bus.mem_wdata1, 0);
        chk("reset_wdata2", bus.mem_wdata2, 0);
        chk("reset_rdata", bus.resp_rdata, 0);
        chk("reset_err", bus.resp_err, 0);
        chk("reset_ready", bus.req_ready, 1);
        @(posedge clk);
        #1;

        issue(0, 3'b010, 32'h100, 0);
        res("lw_100", 32'h1234_5678, 0, 4);

        issue(1, 3'b001, 32'h20, 32'hAAAA_BEEF);
        res("sh_20", 32'h0, 0, 3);
        chk("sh_ram20", ram_rd(32'h20), 32'hEF);
        chk("sh_ram21", ram_rd(32'h21), 32'hBE);
        chk("sh_ram22", ram_rd(32'h22), 32'h5A);

        issue(0, 3'b001, 32'h20, 0);
        res("lh_20", 32'hFFFF_BEEF, 0, 3);
        issue(0, 3'b000, 32'h7, 0);
        res("lb_7", 32'hFFFF_FF80, 0, 3);
        issue(0, 3'b100, 32'h7, 0);
        res("lbu_7", 32'h0000_0080, 0, 3);

        issue(0, 3'b011, 32'h100, 0);
        res("f3_011", 32'h0, 1, 1);
        issue(1, 3'b100, 32'h22, 32'hFF);
        res("sbu_illegal", 32'h0, 1, 1);
        chk("sbu_ram22", ram_rd(32'h22), 32'h5A);

        issue(0, 3'b101, 32'h100, 0);
        res("lhu_100", 32'h0000_5678, 0, 3);
        issue(0, 3'b001, 32'h102, 0);
        res("lh_102", 32'h0000_1234, 0, 3);

        issue(1, 3'b010, 32'h200, 32'h89AB_CDEF);
        res("sw_200", 32'h0, 0, 4);
        issue(0, 3'b010, 32'h200, 0);
        res("lw_200", 32'h89AB_CDEF, 0, 4);
        issue(0, 3'b000, 32'h203, 0);
        res("lb_203", 32'hFFFF_FF89, 0, 3);
        issue(0, 3'b101, 32'h202, 0);
        res("lhu_202", 32'h0000_89AB, 0, 3);

`ifdef MISALIGN_CHECK_EN
        issue(0, 3'b010, 32'h3, 0);
        res("lw_3", 32'h0, 1, 1);
        issue(0, 3'b010, 32'hFFFF_FFFF, 0);
        res("lw_wrap", 32'h0, 1, 1);
        issue(0, 3'b101, 32'h101, 0);
        res("lhu_101", 32'h0, 1, 1);
`else
        issue(0, 3'b010, 32'h3, 0);
        res("lw_3", 32'hD4C3_B2A1, 0, 4);
        issue(0, 3'b010, 32'hFFFF_FFFF, 0);
        res("lw_wrap", 32'h4433_2211, 0, 4);
        issue(0, 3'b101, 32'h101, 0);
        res("lhu_101", 32'h0000_3456, 0, 3);
`endif

        send(1, 3'b010, 32'h40, 32'hDDCC_BBAA);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ref_mem[32'h42] = 8'h03;
        ref_mem[32'h43] = 8'h04;
        @(negedge clk);
        chk("rst_mid_ready", bus.req_ready, 1);
        chk("rst_mid_ram40", ram_rd(32'h40), 32'hAA);
        chk("rst_mid_ram41", ram_rd(32'h41), 32'hBB);
        chk("rst_mid_ram42", ram_rd(32'h42), 32'h03);
        chk("rst_mid_ram43", ram_rd(32'h43), 32'h04);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_noresp", resp_cnt, cnt0);

        issue(0, 3'b010, 32'h40, 0);
        res("lw_40", 32'h0403_BBAA, 0, 4);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end
endmodule
